// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle MIPS control unit.
// MC_BNE_EN adds the BNEEX state for the bne instruction.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
`ifdef MC_BNE_EN
        BNEEX   = 4'd12,
`endif
        JEX     = 4'd11
    } statetype_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_RSVD  = 2'b11
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_controller_aludec.sv
// Combinational ALU decoder: maps aluop and R-type funct to an ALU operation.
module aludec
    import mc_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore main FSM plus ALU decoder.
// Define MC_BNE_EN to add bne support through the BNEEX state.
module mc_controller
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcEn,
    output logic       IorD,
    output logic       memwrite,
    output logic       IRwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrcA,
    output logic [1:0] alusrcB,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    statetype_t state_reg, state_next;
    aluop_t     aluop;
    logic       pcwrite, branch, memwrite_dec, IRwrite_dec, regwrite_dec;
    logic       branch_taken;
`ifdef MC_BNE_EN
    logic       bne;
`endif

    always_ff @(posedge clk) begin
        if (reset) state_reg <= FETCH;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next   = FETCH;
        IorD         = 1'b0;
        memwrite_dec = 1'b0;
        IRwrite_dec  = 1'b0;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        regwrite_dec = 1'b0;
        alusrcA      = 1'b0;
        alusrcB      = 2'b00;
        pcsrc        = 2'b00;
        aluop        = ALUOP_ADD;
        pcwrite      = 1'b0;
        branch       = 1'b0;
`ifdef MC_BNE_EN
        bne          = 1'b0;
`endif
        case (state_reg)
            FETCH: begin
                alusrcB     = 2'b01;
                IRwrite_dec = 1'b1;
                pcwrite     = 1'b1;
                state_next  = DECODE;
            end
            DECODE: begin
                // Precompute the branch target into aluout.
                alusrcB = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = RTYPEEX;
                    OP_BEQ:       state_next = BEQEX;
                    OP_ADDI:      state_next = ADDIEX;
                    OP_J:         state_next = JEX;
`ifdef MC_BNE_EN
                    OP_BNE:       state_next = BNEEX;
`endif
                    default:      state_next = FETCH;
                endcase
            end
            MEMADR: begin
                alusrcA    = 1'b1;
                alusrcB    = 2'b10;
                state_next = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                IorD       = 1'b1;
                state_next = MEMWB;
            end
            MEMWB: begin
                memtoreg     = 1'b1;
                regwrite_dec = 1'b1;
            end
            MEMWR: begin
                IorD         = 1'b1;
                memwrite_dec = 1'b1;
            end
            RTYPEEX: begin
                alusrcA    = 1'b1;
                aluop      = ALUOP_FUNCT;
                state_next = RTYPEWB;
            end
            RTYPEWB: begin
                regdst       = 1'b1;
                regwrite_dec = 1'b1;
            end
            BEQEX: begin
                alusrcA = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
`ifdef MC_BNE_EN
            BNEEX: begin
                alusrcA = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                bne     = 1'b1;
            end
`endif
            ADDIEX: begin
                alusrcA    = 1'b1;
                alusrcB    = 2'b10;
                state_next = ADDIWB;
            end
            ADDIWB: regwrite_dec = 1'b1;
            JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: state_next = FETCH;
        endcase
    end

`ifdef MC_BNE_EN
    assign branch_taken = (branch & zero) | (bne & ~zero);
`else
    assign branch_taken = branch & zero;
`endif

    // Write enables are held low during reset so an abandoned instruction cannot commit.
    assign pcEn     = (pcwrite | branch_taken) & ~reset;
    assign memwrite = memwrite_dec & ~reset;
    assign IRwrite  = IRwrite_dec & ~reset;
    assign regwrite = regwrite_dec & ~reset;
    assign state    = state_reg;

    aludec u_aludec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule
